// File: rtl/rr_request_scheduler.sv
// -----------------------------------------------------------------------------
// rr_request_scheduler
//
// Round-robin scheduler that shares one display/LED resource between up to
// N_REQ requesters. One requester holds the grant at a time, for at most
// HOLD_CYCLES cycles. After every grant there is exactly one idle (GAP) cycle
// before the next arbitration. Round-robin order keeps low-numbered
// requesters from starving the others, which a fixed-priority encoder would
// allow.
//
// Ports
//   i_clk          in   1      system clock, rising edge
//   i_reset        in   1      asynchronous, active-low reset
//   i_req          in   N_REQ  request levels, bit i = requester i
//   i_release      in   1      button level; a rising edge ends a grant early
//   o_grant        out  N_REQ  one-hot grant (registered)
//   o_grant_idx    out  IDX_W  index of granted requester (registered)
//   o_grant_valid  out  1      high while a grant is active (registered)
// -----------------------------------------------------------------------------
module rr_request_scheduler #(
  parameter int N_REQ       = 8,
  parameter int HOLD_CYCLES = 1000,
  parameter int IDX_W       = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_release,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_grant_valid
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rel_q;
  logic [N_REQ-1:0] r_grant;
  logic [IDX_W-1:0] r_grant_idx;
  logic             r_grant_valid;

  logic             w_found;
  logic [IDX_W-1:0] w_win;
  logic [N_REQ-1:0] w_onehot;
  logic             w_req_held;
  logic             w_rel_edge;
  logic             w_end;
  logic [IDX_W-1:0] w_ptr_next;

  // Round-robin search: first set request at r_ptr, r_ptr+1, ... (mod N_REQ).
  // The loop runs from the farthest offset down to offset 0, so the nearest
  // hit is the last one written and wins.
  always_comb begin : arb_comb
    logic [31:0]      v_pos;
    logic [N_REQ-1:0] v_sh;
    w_found = 1'b0;
    w_win   = {IDX_W{1'b0}};
    v_pos   = 32'd0;
    v_sh    = {N_REQ{1'b0}};
    for (int k = N_REQ - 1; k >= 0; k--) begin
      v_pos = 32'(r_ptr) + 32'(k);
      if (v_pos >= 32'(N_REQ)) begin
        v_pos = v_pos - 32'(N_REQ);
      end else begin
        v_pos = v_pos;
      end
      v_sh = i_req >> v_pos;
      if (v_sh[0]) begin
        w_found = 1'b1;
        w_win   = v_pos[IDX_W-1:0];
      end else begin
        w_found = w_found;
      end
    end
  end

  assign w_onehot   = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
  // The grant is one-hot, so masking i_req with it reads i_req[w].
  assign w_req_held = |(i_req & r_grant);
  assign w_rel_edge = i_release & ~r_rel_q;
  // Any combination of the three end conditions gives a single termination.
  assign w_end      = (r_cnt == {CNT_W{1'b0}}) | ~w_req_held | w_rel_edge;
  assign w_ptr_next = (r_grant_idx == IDX_W'(N_REQ - 1)) ? {IDX_W{1'b0}}
                    : r_grant_idx + {{(IDX_W-1){1'b0}}, 1'b1};

  // Scheduler FSM with registered grant outputs and release edge tracking.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= ST_IDLE;
      r_ptr         <= {IDX_W{1'b0}};
      r_cnt         <= {CNT_W{1'b0}};
      r_rel_q       <= 1'b0;
      r_grant       <= {N_REQ{1'b0}};
      r_grant_idx   <= {IDX_W{1'b0}};
      r_grant_valid <= 1'b0;
    end else begin
      r_rel_q <= i_release;
      case (r_state)
        ST_IDLE, ST_GAP: begin
          if (w_found) begin
            r_grant       <= w_onehot;
            r_grant_idx   <= w_win;
            r_grant_valid <= 1'b1;
            r_cnt         <= CNT_W'(HOLD_CYCLES - 1);
            r_state       <= ST_GRANT;
          end else begin
            r_grant       <= {N_REQ{1'b0}};
            r_grant_idx   <= {IDX_W{1'b0}};
            r_grant_valid <= 1'b0;
            r_state       <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (w_end) begin
            r_grant       <= {N_REQ{1'b0}};
            r_grant_idx   <= {IDX_W{1'b0}};
            r_grant_valid <= 1'b0;
            r_cnt         <= {CNT_W{1'b0}};
            r_ptr         <= w_ptr_next;
            r_state       <= ST_GAP;
          end else begin
            r_cnt         <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_grant       <= {N_REQ{1'b0}};
          r_grant_idx   <= {IDX_W{1'b0}};
          r_grant_valid <= 1'b0;
          r_cnt         <= {CNT_W{1'b0}};
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_idx   = r_grant_idx;
  assign o_grant_valid = r_grant_valid;

endmodule

// File: tb/tb_rr_request_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rr_request_scheduler
//
// Directed bench for rr_request_scheduler with N_REQ=8, HOLD_CYCLES=4.
// Each step drives i_req/i_release on the falling edge, pushes the expected
// post-edge outputs into a scoreboard queue, and after the rising edge pops
// the entry and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_rr_request_scheduler;

  localparam int N_REQ = 8;
  localparam int HOLD  = 4;
  localparam int IDX_W = 4;

  logic             i_clk;
  logic             i_reset;
  logic [N_REQ-1:0] i_req;
  logic             i_release;
  logic [N_REQ-1:0] o_grant;
  logic [IDX_W-1:0] o_grant_idx;
  logic             o_grant_valid;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  rr_request_scheduler #(
    .N_REQ       (N_REQ),
    .HOLD_CYCLES (HOLD),
    .IDX_W       (IDX_W)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_req         (i_req),
    .i_release     (i_release),
    .o_grant       (o_grant),
    .o_grant_idx   (o_grant_idx),
    .o_grant_valid (o_grant_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare all three outputs against an expected (valid, idx) pair.
  task automatic check_out(input string tag, input exp_t e);
    logic [N_REQ-1:0] eg;
    eg = e.valid ? (8'h01 << e.idx) : 8'h00;
    check({tag, ".valid"}, 32'(o_grant_valid), 32'(e.valid));
    check({tag, ".idx"},   32'(o_grant_idx),   32'(e.idx));
    check({tag, ".grant"}, 32'(o_grant),       32'(eg));
  endtask

  task automatic step(input string tag, input logic [7:0] req, input logic rel,
                      input logic ev, input logic [3:0] ei);
    exp_t e;
    @(negedge i_clk);
    i_req     = req;
    i_release = rel;
    e.valid   = ev;
    e.idx     = ei;
    sb_q.push_back(e);
    @(posedge i_clk);
    #1;
    if (sb_q.size() == 0) begin
      n_mis++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      check_out(tag, sb_q.pop_front());
    end
  endtask

  initial begin
    exp_t zero_e;
    zero_e    = '{valid: 1'b0, idx: 4'd0};
    i_reset   = 1'b1;
    i_req     = 8'h00;
    i_release = 1'b0;
    #3 i_reset = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    check_out("reset", zero_e);
    i_reset = 1'b1;

    // 1: sole requester 2, 4-cycle grants separated by one gap, regranted
    repeat (HOLD) step("t1_g1", 8'h04, 1'b0, 1'b1, 4'd2);
    step("t1_gap1", 8'h04, 1'b0, 1'b0, 4'd0);
    repeat (HOLD) step("t1_g2", 8'h04, 1'b0, 1'b1, 4'd2);
    step("t1_gap2", 8'h04, 1'b0, 1'b0, 4'd0);

    // 2: requesters 0 and 7 alternate; pointer is 3 so 7 comes first
    repeat (2) begin
      repeat (HOLD) step("t2_g7", 8'h81, 1'b0, 1'b1, 4'd7);
      step("t2_gap7", 8'h81, 1'b0, 1'b0, 4'd0);
      repeat (HOLD) step("t2_g0", 8'h81, 1'b0, 1'b1, 4'd0);
      step("t2_gap0", 8'h81, 1'b0, 1'b0, 4'd0);
    end
    repeat (HOLD) step("t2_g7b", 8'h81, 1'b0, 1'b1, 4'd7);
    step("t2_gap7b", 8'h81, 1'b0, 1'b0, 4'd0);

    // 3: release edge in the 2nd grant cycle of idx 0 ends it; idx 1 follows
    step("t3_g0a", 8'h03, 1'b0, 1'b1, 4'd0);
    step("t3_g0b", 8'h03, 1'b0, 1'b1, 4'd0);
    step("t3_rel", 8'h03, 1'b1, 1'b0, 4'd0);
    // release held high must not retrigger
    step("t3_g1a", 8'h03, 1'b1, 1'b1, 4'd1);
    step("t3_g1b", 8'h03, 1'b1, 1'b1, 4'd1);
    step("t3_g1c", 8'h03, 1'b0, 1'b1, 4'd1);
    step("t3_g1d", 8'h03, 1'b0, 1'b1, 4'd1);
    // release edge together with hold expiry: single termination, ptr -> 2
    step("t3_both", 8'h03, 1'b1, 1'b0, 4'd0);
    repeat (HOLD) step("t3_g2", 8'h0C, 1'b0, 1'b1, 4'd2);
    step("t3_gap2", 8'h0C, 1'b0, 1'b0, 4'd0);

    // 4: requester 3 drops mid-grant, then idle; release in idle ignored
    step("t4_g3a", 8'h08, 1'b0, 1'b1, 4'd3);
    step("t4_g3b", 8'h08, 1'b0, 1'b1, 4'd3);
    step("t4_drop", 8'h00, 1'b0, 1'b0, 4'd0);
    step("t4_idle", 8'h00, 1'b0, 1'b0, 4'd0);
    step("t4_relidle", 8'h00, 1'b1, 1'b0, 4'd0);
    step("t4_idle2", 8'h00, 1'b0, 1'b0, 4'd0);

    // 5: idx 6 completes (ptr=7); bit 0 arriving mid-grant is ignored,
    //    then wrap gives idx 0, then idx 6
    repeat (HOLD - 1) step("t5_g6", 8'h40, 1'b0, 1'b1, 4'd6);
    step("t5_g6late", 8'h41, 1'b0, 1'b1, 4'd6);
    step("t5_gap6", 8'h41, 1'b0, 1'b0, 4'd0);
    repeat (HOLD) step("t5_wrap0", 8'h41, 1'b0, 1'b1, 4'd0);
    step("t5_gap0", 8'h41, 1'b0, 1'b0, 4'd0);
    step("t5_g6b", 8'h41, 1'b0, 1'b1, 4'd6);

    // 6: asynchronous reset mid-grant; ptr returns to 0
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    check_out("t6_async", zero_e);
    @(negedge i_clk);
    check_out("t6_held", zero_e);
    i_req   = 8'h00;
    i_reset = 1'b1;
    step("t6_idle", 8'h00, 1'b0, 1'b0, 4'd0);
    repeat (HOLD) step("t6_g0", 8'h41, 1'b0, 1'b1, 4'd0);
    step("t6_gap0", 8'h41, 1'b0, 1'b0, 4'd0);
    step("t6_g6", 8'h41, 1'b0, 1'b1, 4'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
